// File: rtl/ksa32_share_ctrl.sv
// Round-robin front end that time-shares one 32-bit Kogge-Stone adder among NUM_REQ clients.
// Operands are registered on grant, the adder result is captured one cycle later and held until the response is taken.
module ksa32_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_sum,
  input  logic                  add_cout,
  input  logic                  add_ovf,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic            grant_found;
  logic            accept;
  logic            rsp_fire;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic [ID_W-1:0] op_id;

  // Rotating priority: search starts one past the previous winner and wraps.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the sender holds data stable until it does.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rsp_fire  = 1'b0;
    req_ready = '0;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          accept               = 1'b1;
          req_ready[grant_idx] = 1'b1;
          state_nxt            = S_EXEC;
        end
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          rsp_fire  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_id     <= '0;
      ops_count  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a       <= req_a[32*grant_idx +: 32];
        op_b       <= req_b[32*grant_idx +: 32];
        op_id      <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == S_EXEC) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
        rsp_ovf  <= add_ovf;
        rsp_id   <= op_id;
      end
      if (rsp_fire) begin
        ops_count <= ops_count + CNT_W'(1);
      end
    end
  end

  // Adder inputs come straight from the operand registers so they stay put between grants.
  assign add_a     = op_a;
  assign add_b     = op_b;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_ksa32_share_ctrl.sv
// Directed bench for ksa32_share_ctrl: a behavioural 32-bit adder sits behind each instance,
// and a second instance with a 2-bit counter covers counter wrap.
module tb_ksa32_share_ctrl;
  localparam int N = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic           rsp_ready;

  logic [N-1:0] req_ready;
  logic [31:0]  add_a, add_b, add_sum;
  logic         add_cout, add_ovf;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
  logic         rsp_cout, rsp_ovf, busy;
  logic [15:0]  ops_count;
  logic [1:0]   dbg_state;

  logic [N-1:0] w_req_ready;
  logic [31:0]  w_add_a, w_add_b, w_add_sum;
  logic         w_add_cout, w_add_ovf;
  logic         w_rsp_valid;
  logic [1:0]   w_rsp_id;
  logic [31:0]  w_rsp_sum;
  logic         w_rsp_cout, w_rsp_ovf, w_busy;
  logic [1:0]   w_ops_count;
  logic [1:0]   w_dbg_state;

  // behavioural adders standing in for the Kogge-Stone instance
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};
  assign add_ovf = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
  assign {w_add_cout, w_add_sum} = {1'b0, w_add_a} + {1'b0, w_add_b};
  assign w_add_ovf = (w_add_a[31] == w_add_b[31]) && (w_add_sum[31] != w_add_a[31]);

  ksa32_share_ctrl #(.NUM_REQ(N), .ID_W(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .add_cout(add_cout), .add_ovf(add_ovf), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .busy(busy), .ops_count(ops_count), .dbg_state(dbg_state)
  );

  ksa32_share_ctrl #(.NUM_REQ(N), .ID_W(2), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(w_req_ready), .add_a(w_add_a), .add_b(w_add_b), .add_sum(w_add_sum),
    .add_cout(w_add_cout), .add_ovf(w_add_ovf), .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(w_rsp_id), .rsp_sum(w_rsp_sum), .rsp_cout(w_rsp_cout), .rsp_ovf(w_rsp_ovf),
    .busy(w_busy), .ops_count(w_ops_count), .dbg_state(w_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // driver tasks
  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid[id] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      waited++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {req_ready, rsp_valid, busy});
    end
    checks++;
    if ({add_a, add_b} !== 64'h0) begin
      errors++;
      $display("FAIL reset_operands: got %h expected 0", {add_a, add_b});
    end
    checks++;
    if ({rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== 36'h0) begin
      errors++;
      $display("FAIL reset_rsp: got %h expected 0", {rsp_id, rsp_sum, rsp_cout, rsp_ovf});
    end
    checks++;
    if (ops_count !== 16'h0 || w_ops_count !== 2'h0) begin
      errors++;
      $display("FAIL reset_count: got %h/%h expected 0/0", ops_count, w_ops_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    int waited;
    @(negedge clk);
    req_a[31:0] = 32'h0000_0001;
    req_b[31:0] = 32'h0000_0002;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL basic_ready: got %b expected 0001", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(ok, waited);
    checks++;
    if (!ok || waited != 2) begin
      errors++;
      $display("FAIL basic_latency: got ok=%0d cycles=%0d expected ok=1 cycles=2", ok, waited);
    end
    checks++;
    if ({rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {2'd0, 32'h0000_0003, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_rsp: got id=%0d sum=%h c=%b v=%b expected id=0 sum=00000003 c=0 v=0",
               rsp_id, rsp_sum, rsp_cout, rsp_ovf);
    end
    checks++;
    if (ops_count !== 16'd0) begin
      errors++;
      $display("FAIL basic_count_pre: got %0d expected 0", ops_count);
    end
    @(negedge clk);
    checks++;
    if (ops_count !== 16'd1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_count_post: got count=%0d valid=%b expected count=1 valid=0", ops_count, rsp_valid);
    end
  endtask

  task automatic test_flags();
    bit ok;
    int waited;
    run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, ok);
    wait_rsp(ok, waited);
    checks++;
    if (!ok || {rsp_sum, rsp_cout, rsp_ovf} !== {32'h8000_0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL flags_ovf: got ok=%0d sum=%h c=%b v=%b expected sum=80000000 c=0 v=1",
               ok, rsp_sum, rsp_cout, rsp_ovf);
    end
    @(negedge clk);
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, ok);
    wait_rsp(ok, waited);
    checks++;
    if (!ok || {rsp_sum, rsp_cout, rsp_ovf} !== {32'h0000_0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL flags_cout: got ok=%0d sum=%h c=%b v=%b expected sum=00000000 c=1 v=0",
               ok, rsp_sum, rsp_cout, rsp_ovf);
    end
    @(negedge clk);
    checks++;
    if (ops_count !== 16'd3) begin
      errors++;
      $display("FAIL flags_count: got %0d expected 3", ops_count);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] ta[4] = '{32'h0000_0010, 32'h1111_1111, 32'h8000_0000, 32'hFFFF_FFFE};
    logic [31:0] tb[4] = '{32'h0000_0020, 32'h2222_2222, 32'h8000_0000, 32'h0000_0003};
    logic [1:0]  fl[4] = '{2'b00, 2'b00, 2'b11, 2'b10};
    logic [1:0]  exp_id[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] exp_sum;
    bit ok;
    int waited;
    int prev;
    apply_reset();
    exp_q = '{32'h0000_0030, 32'h3333_3333, 32'h0000_0000, 32'h0000_0001, 32'h0000_0030};
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = ta[i];
      req_b[32*i +: 32] = tb[i];
    end
    req_valid = 4'hF;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_rsp(ok, waited);
      exp_sum = exp_q.pop_front();
      checks++;
      if (!ok || rsp_id !== exp_id[n]) begin
        errors++;
        $display("FAIL rr_id[%0d]: got ok=%0d id=%0d expected id=%0d", n, ok, rsp_id, exp_id[n]);
      end
      checks++;
      if ({rsp_sum, rsp_cout, rsp_ovf} !== {exp_sum, fl[exp_id[n]]}) begin
        errors++;
        $display("FAIL rr_sum[%0d]: got %h c=%b v=%b expected %h flags=%b",
                 n, rsp_sum, rsp_cout, rsp_ovf, exp_sum, fl[exp_id[n]]);
      end
      if (n > 0) begin
        checks++;
        if (cyc - prev != 3) begin
          errors++;
          $display("FAIL rr_interval[%0d]: got %0d expected 3", n, cyc - prev);
        end
      end
      prev = cyc;
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (ops_count !== 16'd5 || w_ops_count !== 2'd1) begin
      errors++;
      $display("FAIL rr_count: got %0d/%0d expected 5/1", ops_count, w_ops_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int waited;
    rsp_ready = 1'b0;
    run_op(2, 32'h0000_0005, 32'h0000_0006, ok);
    req_a[63:32] = 32'h0000_0100;
    req_b[63:32] = 32'h0000_0200;
    req_valid[1] = 1'b1;
    wait_rsp(ok, waited);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_rsp_timeout: got no rsp_valid expected rsp_valid=1");
    end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {1'b1, 2'd2, 32'h0000_000B, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h expected v=1 id=2 sum=0000000b",
                 c, rsp_valid, rsp_id, rsp_sum);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_next_grant: got %b expected 0010", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(ok, waited);
    checks++;
    if (!ok || {rsp_id, rsp_sum} !== {2'd1, 32'h0000_0300}) begin
      errors++;
      $display("FAIL bp_next_rsp: got ok=%0d id=%0d sum=%h expected id=1 sum=00000300", ok, rsp_id, rsp_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_exec();
    bit ok;
    int waited;
    int seen;
    @(negedge clk);
    req_a[127:96] = 32'h0000_000A;
    req_b[127:96] = 32'h0000_000B;
    req_valid[3] = 1'b1;
    @(posedge clk);
    #2;
    req_valid = '0;
    checks++;
    if (busy !== 1'b1 || dbg_state !== 2'd1 || add_a !== 32'h0000_000A) begin
      errors++;
      $display("FAIL rx_in_exec: got busy=%b state=%0d a=%h expected busy=1 state=1 a=0000000a",
               busy, dbg_state, add_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, rsp_valid, req_ready} !== 6'b0 || {add_a, add_b} !== 64'h0 || ops_count !== 16'd0) begin
      errors++;
      $display("FAIL rx_async: got busy=%b v=%b a=%h cnt=%0d expected all 0", busy, rsp_valid, add_a, ops_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rx_no_rsp: got %0d responses expected 0", seen);
    end
    req_a[31:0] = 32'h0000_0004;
    req_b[31:0] = 32'h0000_0005;
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rx_first_grant: got %b expected 0001", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(ok, waited);
    checks++;
    if (!ok || {rsp_id, rsp_sum} !== {2'd0, 32'h0000_0009}) begin
      errors++;
      $display("FAIL rx_rsp: got ok=%0d id=%0d sum=%h expected id=0 sum=00000009", ok, rsp_id, rsp_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [1:0] exp_w[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    bit ok;
    int waited;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      run_op(0, 32'(i), 32'h0000_0001, ok);
      wait_rsp(ok, waited);
      @(negedge clk);
      checks++;
      if (!ok || w_ops_count !== exp_w[i] || ops_count !== 16'(i + 1)) begin
        errors++;
        $display("FAIL wrap_count[%0d]: got ok=%0d w=%0d c=%0d expected w=%0d c=%0d",
                 i, ok, w_ops_count, ops_count, exp_w[i], i + 1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_basic();
    test_flags();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
